// File: rtl/max_idx_seq.sv
`default_nettype none
// ============================================================================
// Module   : max_idx_seq
// Purpose  : Handshaked argmax engine. Returns the index and value of the
//            largest of N signed inputs by reducing a working list with
//            NCMP time-multiplexed compare-and-select units. The lowest
//            index wins ties.
// Ports    : clk        - clock, rising edge
//            reset_n    - asynchronous active-low reset
//            in_valid   - frame (inputs, mask) valid
//            in_ready   - engine can accept a frame
//            inputs     - N x WIDTH signed candidates, element i has index i
//            mask       - (MAX_IDX_MASK_EN only) bit i=1 excludes element i
//            out_valid  - result valid, held until out_ready
//            out_ready  - consumer accepts result
//            idx        - index of the maximum
//            max_val    - value of the maximum
//            none       - (MAX_IDX_MASK_EN only) every element was masked
// Config   : define MAX_IDX_MASK_EN to add the mask/none ports and the
//            dead-entry handling.
// Revision : 1.0 - initial release
// ============================================================================
module max_idx_seq #(
    parameter int WIDTH = 8,
    parameter int N     = 10,
    parameter int NCMP  = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0][WIDTH-1:0] inputs,
`ifdef MAX_IDX_MASK_EN
    input  logic [N-1:0]            mask,
    output logic                    none,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        idx,
    output logic signed [WIDTH-1:0] max_val
);

    localparam int CNT_W = $clog2(N + 1);

    typedef struct packed {
        logic signed [WIDTH-1:0] val;
        logic [IDX_W-1:0]        idx;
`ifdef MAX_IDX_MASK_EN
        logic                    live;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    entry_t                  w_q     [N];
    entry_t                  w_d     [N];
    entry_t                  ld      [N];
    entry_t                  cmp_res [N];
    int                      n_pairs;
    logic                    out_valid_q;
    logic [IDX_W-1:0]        idx_q;
    logic signed [WIDTH-1:0] max_val_q;
`ifdef MAX_IDX_MASK_EN
    logic                    none_q;
`endif

    // Operand a always carries the lower original index, so keeping a on
    // equality gives lowest-index-wins tie breaking.
    function automatic entry_t sel(input entry_t a, input entry_t b);
        entry_t r;
`ifdef MAX_IDX_MASK_EN
        if (a.live && b.live) begin
            r = ($signed(b.val) > $signed(a.val)) ? b : a;
        end else if (b.live) begin
            r = b;
        end else begin
            r = a;
        end
`else
        r = ($signed(b.val) > $signed(a.val)) ? b : a;
`endif
        return r;
    endfunction

    // Unit k pairs W[2k] with W[2k+1]; slots beyond the real units just pass
    // their entry through and are never selected.
    for (genvar k = 0; k < N; k++) begin : g_unit
        if (k < NCMP && 2 * k + 1 < N) begin : g_cmp
            assign cmp_res[k] = sel(w_q[2 * k], w_q[2 * k + 1]);
        end else begin : g_pass
            assign cmp_res[k] = w_q[k];
        end
    end

    // Frame load: every entry starts live unless masked.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            ld[j].val  = inputs[j];
            ld[j].idx  = IDX_W'(j);
`ifdef MAX_IDX_MASK_EN
            ld[j].live = ~mask[j];
`endif
        end
    end

    // One reduction step: the P winners go to the front, the untouched tail
    // W[2P..] shifts down by P, preserving original index order.
    always_comb begin
        n_pairs = int'(cnt_q) >> 1;
        if (n_pairs > NCMP) begin
            n_pairs = NCMP;
        end
        for (int j = 0; j < N; j++) begin
            w_d[j] = w_q[j];
            if (j < n_pairs) begin
                w_d[j] = cmp_res[j];
            end else begin
                for (int s = 0; s < N; s++) begin
                    if (s == j + n_pairs) begin
                        w_d[j] = w_q[s];
                    end
                end
            end
        end
        cnt_d = cnt_q - CNT_W'(n_pairs);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            max_val_q   <= '0;
`ifdef MAX_IDX_MASK_EN
            none_q      <= 1'b0;
`endif
            for (int j = 0; j < N; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < N; j++) begin
                            w_q[j] <= ld[j];
                        end
                        cnt_q   <= CNT_W'(N);
                        state_q <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    for (int j = 0; j < N; j++) begin
                        w_q[j] <= w_d[j];
                    end
                    cnt_q <= cnt_d;
                    if (cnt_d == CNT_W'(1)) begin
`ifdef MAX_IDX_MASK_EN
                        if (w_d[0].live) begin
                            idx_q     <= w_d[0].idx;
                            max_val_q <= w_d[0].val;
                            none_q    <= 1'b0;
                        end else begin
                            idx_q     <= '0;
                            max_val_q <= '0;
                            none_q    <= 1'b1;
                        end
`else
                        idx_q     <= w_d[0].idx;
                        max_val_q <= w_d[0].val;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            for (int j = 0; j < N; j++) begin
                                w_q[j] <= ld[j];
                            end
                            cnt_q   <= CNT_W'(N);
                            state_q <= S_REDUCE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by reset_n so the engine never advertises ready while held in reset.
    assign in_ready  = reset_n &&
                       ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
    assign out_valid = out_valid_q;
    assign idx       = idx_q;
    assign max_val   = max_val_q;
`ifdef MAX_IDX_MASK_EN
    assign none      = none_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_max_idx_seq.sv
`default_nettype none
module tb_max_idx_seq;

    localparam int WIDTH = 8;
    localparam int N     = 10;
    localparam int NCMP  = 3;
    localparam int IDX_W = 4;
    localparam int LAT   = 4;

    typedef logic [N-1:0][WIDTH-1:0] frame_t;

    typedef struct {
        logic [IDX_W-1:0]        idx;
        logic signed [WIDTH-1:0] val;
        bit                      none;
        int                      acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (N=10, NCMP=3)
    logic                    reset_n;
    logic                    in_valid;
    logic                    in_ready;
    frame_t                  inputs;
    logic [N-1:0]            mask;
    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        idx;
    logic signed [WIDTH-1:0] max_val;
`ifdef MAX_IDX_MASK_EN
    logic                    none;
`endif

    max_idx_seq #(.WIDTH(WIDTH), .N(N), .NCMP(NCMP)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inputs   (inputs),
`ifdef MAX_IDX_MASK_EN
        .mask     (mask),
        .none     (none),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .idx      (idx),
        .max_val  (max_val)
    );

    // single-comparator variant
    logic                    c1_valid;
    logic                    c1_ready;
    frame_t                  c1_in;
    logic                    c1_ov;
    logic [IDX_W-1:0]        c1_idx;
    logic signed [WIDTH-1:0] c1_val;
`ifdef MAX_IDX_MASK_EN
    logic                    c1_none;
`endif

    max_idx_seq #(.WIDTH(WIDTH), .N(N), .NCMP(1)) u_c1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (c1_valid),
        .in_ready (c1_ready),
        .inputs   (c1_in),
`ifdef MAX_IDX_MASK_EN
        .mask     ('0),
        .none     (c1_none),
`endif
        .out_valid(c1_ov),
        .out_ready(1'b1),
        .idx      (c1_idx),
        .max_val  (c1_val)
    );

    // single-input variant
    logic                    n1_valid;
    logic                    n1_ready;
    logic [WIDTH-1:0]        n1_in;
    logic                    n1_ov;
    logic [0:0]              n1_idx;
    logic signed [WIDTH-1:0] n1_val;
`ifdef MAX_IDX_MASK_EN
    logic                    n1_none;
`endif

    max_idx_seq #(.WIDTH(WIDTH), .N(1), .NCMP(3)) u_n1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (n1_valid),
        .in_ready (n1_ready),
        .inputs   (n1_in),
`ifdef MAX_IDX_MASK_EN
        .mask     (1'b0),
        .none     (n1_none),
`endif
        .out_valid(n1_ov),
        .out_ready(1'b1),
        .idx      (n1_idx),
        .max_val  (n1_val)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: linear scan for the first strictly greater live value.
    function automatic exp_t model(input frame_t v, input logic [N-1:0] m, input int acc);
        exp_t r;
        int   best;
        best = -1;
        for (int i = 0; i < N; i++) begin
            if (!m[i]) begin
                if (best < 0) best = i;
                else if ($signed(v[i]) > $signed(v[best])) best = i;
            end
        end
        r.acc  = acc;
        r.none = (best < 0);
        r.idx  = (best < 0) ? '0 : IDX_W'(best);
        r.val  = (best < 0) ? '0 : v[best];
        return r;
    endfunction

    function automatic frame_t mk(input int a[N]);
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = WIDTH'(a[i]);
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) f[i] = WIDTH'($urandom_range(0, 3));
            else f[i] = WIDTH'($urandom);
        end
        return f;
    endfunction

    task automatic monitor();
        bit   seen;
        exp_t h;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                seen = 0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", out_valid, 0);
                    end else begin
                        h = exp_q[0];
                        if (!seen) begin
                            chk("latency", cyc - h.acc, LAT);
                            seen = 1;
                        end
                        chk("idx", idx, h.idx);
                        chk("max_val", max_val, h.val);
`ifdef MAX_IDX_MASK_EN
                        chk("none", none, h.none);
`endif
                        chk("in_ready_out", in_ready, out_ready);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            seen = 0;
                        end
                    end
                end else begin
                    chk("in_ready_idle", in_ready, (exp_q.size() == 0) ? 1 : 0);
                end
                if (in_valid && in_ready) exp_q.push_back(model(inputs, mask, cyc + 1));
            end
        end
    endtask

    // Called at #1 after a posedge; returns at #1 after the accept edge.
    task automatic send(input frame_t v, input logic [N-1:0] m);
        in_valid = 1'b1;
        inputs   = v;
        mask     = m;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic aux_c1(input frame_t v);
        exp_t e;
        int   lat;
        e = model(v, '0, 0);
        c1_in    = v;
        c1_valid = 1'b1;
        @(negedge clk);
        chk("c1_in_ready", c1_ready, 1);
        @(posedge clk);
        #1 c1_valid = 1'b0;
        lat = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            lat++;
            #1;
            if (c1_ov) break;
        end
        chk("c1_latency", lat, 9);
        chk("c1_idx", c1_idx, e.idx);
        chk("c1_max_val", c1_val, e.val);
`ifdef MAX_IDX_MASK_EN
        chk("c1_none", c1_none, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic aux_n1(input logic [WIDTH-1:0] v);
        int lat;
        n1_in    = v;
        n1_valid = 1'b1;
        @(negedge clk);
        chk("n1_in_ready", n1_ready, 1);
        @(posedge clk);
        #1 n1_valid = 1'b0;
        lat = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            lat++;
            #1;
            if (n1_ov) break;
        end
        chk("n1_latency", lat, 1);
        chk("n1_idx", n1_idx, 0);
        chk("n1_max_val", n1_val, $signed(v));
`ifdef MAX_IDX_MASK_EN
        chk("n1_none", n1_none, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int     a[N];
        frame_t f;
        bit     acc;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inputs    = '0;
        mask      = '0;
        c1_valid  = 1'b0;
        c1_in     = '0;
        n1_valid  = 1'b0;
        n1_in     = '0;

        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_idx", idx, 0);
        chk("rst_max_val", max_val, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // reference frame, out_ready held high
        a = '{3, -5, 7, 0, 2, 1, 6, -1, 4, 9};
        send(mk(a), '0);
        repeat (LAT + 3) @(posedge clk);
        #1;

        // all equal: lowest index wins
        a = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        send(mk(a), '0);
        repeat (LAT + 3) @(posedge clk);
        #1;

        // signed compare
        a = '{-128, -128, -128, -1, -128, -128, -128, -128, -128, -128};
        send(mk(a), '0);
        repeat (LAT + 3) @(posedge clk);
        #1;

        // backpressure, then same-cycle re-accept
        out_ready = 1'b0;
        a = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        send(mk(a), '0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        repeat (6) @(posedge clk);
        #1;
        a = '{0, 0, 0, 0, 8, 0, 0, 0, 0, 0};
        inputs    = mk(a);
        mask      = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("same_cycle_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;

        // reset in the middle of REDUCE
        a = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        send(mk(a), '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_max_val", max_val, 0);
        chk("midrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        a = '{-3, 12, -7, 40, 2, 1, 39, -1, 4, 9};
        send(mk(a), '0);
        repeat (LAT + 3) @(posedge clk);
        #1;

`ifdef MAX_IDX_MASK_EN
        a = '{3, -5, 7, 0, 2, 1, 6, -1, 4, 9};
        send(mk(a), 10'b10_0000_0000);
        repeat (LAT + 3) @(posedge clk);
        #1;
        send(mk(a), '1);
        repeat (LAT + 3) @(posedge clk);
        #1;
`endif

        // randomized traffic with random backpressure
        acc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 2) != 0);
                inputs   = rand_frame();
`ifdef MAX_IDX_MASK_EN
                if ($urandom_range(0, 7) == 0) mask = '1;
                else mask = N'($urandom) & N'($urandom);
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // variants: NCMP=1 and N=1
        a = '{3, -5, 7, 0, 2, 1, 6, -1, 4, 9};
        aux_c1(mk(a));
        aux_c1(rand_frame());
        aux_n1(8'h80);
        aux_n1(8'h7f);
        aux_n1(WIDTH'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
